// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode 7-segment driver with frame-atomic BCD loading.
// Optional macro HEX_GLYPH_EN: codes 10..15 show hex glyphs A,b,C,d,E,F instead of a dash.
module bcd_scan_display #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] active;

  logic                    adv;
  logic                    wrap;
  logic [3:0]              digit;
  logic                    upper_zero;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   an_next;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
`ifdef HEX_GLYPH_EN
      4'd10:   g = 7'b0001000;
      4'd11:   g = 7'b0000011;
      4'd12:   g = 7'b1000110;
      4'd13:   g = 7'b0100001;
      4'd14:   g = 7'b0000110;
      default: g = 7'b0001110;
`else
      default: g = 7'b0111111;
`endif
    endcase
    return g;
  endfunction

  assign adv  = (cnt == CW'(REFRESH_DIV - 1));
  assign wrap = adv && (idx == IW'(NUM_DIGITS - 1));

  // Digit select, leading-zero scan and anode pattern all keyed off the current idx.
  always_comb begin
    digit      = '0;
    upper_zero = 1'b1;
    an_next    = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) == idx) begin
        digit      = active[4*k +: 4];
        an_next[k] = 1'b0;
      end
      if ((IW'(k) >= idx) && (active[4*k +: 4] != 4'd0))
        upper_zero = 1'b0;
    end
    blank = blank_lz && (idx != '0) && upper_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      active     <= '0;
      seg        <= 7'h7F;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= adv ? '0 : cnt + 1'b1;
      frame_tick <= wrap;
      if (adv)
        idx <= wrap ? '0 : idx + 1'b1;
      // A load coinciding with the wrap bypasses pending so the new frame shows it.
      if (wrap)
        active <= load ? bcd : pending;
      if (load)
        pending <= bcd;
      seg <= blank ? 7'h7F : glyph(digit);
      an  <= blank ? '1 : an_next;
    end
  end

endmodule
